// File: rtl/dma_readback_buffer.sv
// dma_readback_buffer: per-channel CA/CWC snapshot bank read out one byte at a time,
// with the selected word frozen across a multi-byte read.
module dma_readback_buffer #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 16,
  localparam int NBYTES = WIDTH / 8,
  localparam int CHW    = NUM_CH > 1 ? $clog2(NUM_CH) : 1,
  localparam int PW     = NBYTES > 1 ? $clog2(NBYTES) : 1
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic [NUM_CH*WIDTH-1:0] RB_currentAddress_in,
  input  logic [NUM_CH*WIDTH-1:0] RB_currentWordCount_in,
  input  logic                    rd_req,
  input  logic [CHW-1:0]          rd_ch,
  input  logic                    rd_reg,
  input  logic                    clear_ff,
  output logic [7:0]              data_out,
  output logic                    data_valid,
  output logic [PW-1:0]           byte_ptr
);
  localparam int IW    = CHW + 1;
  localparam int DEPTH = 2 ** IW;
  localparam int XW    = (DEPTH / 2) * WIDTH;
  // Entry index is {channel, reg}; inputs are zero-extended to a power-of-two channel count.
  logic [WIDTH-1:0] snap [DEPTH];
  logic [XW-1:0]    ca_x, cwc_x;
  logic             frz;
  logic [IW-1:0]    fidx;
  logic [IW-1:0]    sel;
  logic             in_range, go, last, set_frz;
  logic [WIDTH-1:0] word;
  logic [7:0]       byte_sel;
  assign ca_x     = XW'(RB_currentAddress_in);
  assign cwc_x    = XW'(RB_currentWordCount_in);
  assign sel      = {rd_ch, rd_reg};
  assign in_range = 32'(rd_ch) < 32'(NUM_CH);
  assign go       = rd_req & ~clear_ff;
  assign last     = byte_ptr == PW'(NBYTES - 1);
  assign set_frz  = go & in_range & (byte_ptr == '0) & (NBYTES > 1);
  assign word     = snap[sel];
  assign byte_sel = 8'(word >> {byte_ptr, 3'b000});
  // An entry holds while frozen and also on the edge that freezes it.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int i = 0; i < DEPTH; i++) snap[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (!((frz && fidx == IW'(i)) || (set_frz && sel == IW'(i))))
          snap[i] <= (i % 2 == 1) ? cwc_x[(i/2)*WIDTH +: WIDTH] : ca_x[(i/2)*WIDTH +: WIDTH];
    end
  end
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      byte_ptr   <= '0;
      frz        <= 1'b0;
      fidx       <= '0;
      data_out   <= 8'h00;
      data_valid <= 1'b0;
    end else if (clear_ff) begin
      byte_ptr   <= '0;
      frz        <= 1'b0;
      data_valid <= 1'b0;
    end else begin
      data_valid <= rd_req;
      if (go) begin
        data_out <= in_range ? byte_sel : 8'h00;
        if (set_frz) begin
          frz  <= 1'b1;
          fidx <= sel;
        end
        if (last) begin
          frz      <= 1'b0;
          byte_ptr <= '0;
        end else begin
          byte_ptr <= byte_ptr + 1'b1;
        end
      end
    end
  end
endmodule
